// File: rtl/gen_sub_decomposed_pipe.sv
// Two-stage 4-bit modular subtractor a = (s - b) mod 16 with borrow-out.
// Stage 1 registers the AND product terms; stage 2 merges them with XOR only.
module gen_sub_decomposed_pipe (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] s,
  input  logic [3:0] b,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] a,
  output logic       bout,
  output logic [9:0] n_dbg
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] d;
  logic [9:0] terms;

  logic       s1_load;
  logic       s2_load;

  logic       s1_valid_q, s1_valid_d;
  logic [9:0] s1_n_q, s1_n_d;
  logic [3:0] s1_d_q, s1_d_d;
  logic       s2_valid_q, s2_valid_d;
  logic [3:0] a_q, a_d;
  logic       bout_q, bout_d;

  // Nonlinear part: borrow generate/propagate and every product term.
  always_comb begin
    g = ~s & b;
    p = ~(s ^ b);
    d = s ^ b;
    terms[0] = g[0];
    terms[1] = g[1];
    terms[2] = p[1] & g[0];
    terms[3] = g[2];
    terms[4] = p[2] & g[1];
    terms[5] = p[2] & p[1] & g[0];
    terms[6] = g[3];
    terms[7] = p[3] & g[2];
    terms[8] = p[3] & p[2] & g[1];
    terms[9] = p[3] & p[2] & p[1] & g[0];
  end

  always_comb begin
    in_ready   = ~s1_valid_q | ~s2_valid_q | out_ready;
    s1_load    = in_ready;
    s2_load    = ~s2_valid_q | out_ready;

    s1_valid_d = s1_valid_q;
    s1_n_d     = s1_n_q;
    s1_d_d     = s1_d_q;
    s2_valid_d = s2_valid_q;
    a_d        = a_q;
    bout_d     = bout_q;

    if (s1_load) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_n_d = terms;
        s1_d_d = d;
      end
    end

    // Linear part: terms within one borrow are mutually exclusive, so XOR is exact.
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        a_d[0] = s1_d_q[0];
        a_d[1] = s1_d_q[1] ^ s1_n_q[0];
        a_d[2] = s1_d_q[2] ^ s1_n_q[1] ^ s1_n_q[2];
        a_d[3] = s1_d_q[3] ^ s1_n_q[3] ^ s1_n_q[4] ^ s1_n_q[5];
        bout_d = s1_n_q[6] ^ s1_n_q[7] ^ s1_n_q[8] ^ s1_n_q[9];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_n_q     <= '0;
      s1_d_q     <= '0;
      s2_valid_q <= 1'b0;
      a_q        <= '0;
      bout_q     <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_n_q     <= s1_n_d;
      s1_d_q     <= s1_d_d;
      s2_valid_q <= s2_valid_d;
      a_q        <= a_d;
      bout_q     <= bout_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign a         = a_q;
  assign bout      = bout_q;
  assign n_dbg     = s1_n_q;

endmodule
